// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one result bit per clock, LSB first,
// with a registered borrow chain and a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             d_bit;
    logic             bout;

    // Full-subtractor cell on the operand LSBs and the stored borrow
    always_comb begin
        d_bit = a_q[0] ^ b_q[0] ^ brw_q;
        bout  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
        res_d = {d_bit, res_q[WIDTH-1:1]};
    end

    // Control FSM and datapath; outputs only move on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    brw_q <= bout;
                    if (cnt_q == LAST) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        diff_q   <= res_d;
                        borrow_q <= bout;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected
// {borrow,diff}; a negedge monitor pops and compares on each done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int run = 0;
    int last_done = 0;
    int prev_done = 0;
    logic [W-1:0] held = '0;
    logic [W:0] sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .diff(diff),
        .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            run = 0;
            held = '0;
        end else if (busy) begin
            run++;
        end
        if (done) begin
            prev_done = last_done;
            last_done = cyc;
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0)
                chk("result", 32'({borrow_out, diff}), 32'(sb.pop_front()));
            chk("busy_len", 32'(run), 32'(W));
            chk("busy_in_done", 32'(busy), 32'd0);
            run = 0;
            held = diff;
        end else if (rst_n) begin
            chk("diff_hold", 32'(diff), 32'(held));
        end
    end

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL timeout: done not seen, want done=1");
        end
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W:0] exp);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done();
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("reset_out", 32'({borrow_out, diff}), 32'd0);
        chk("reset_ctl", 32'({busy, done}), 32'd0);
        rst_n = 1'b1;

        op(8'h5A, 8'h3C, {1'b0, 8'h1E});
        op(8'h00, 8'h01, {1'b1, 8'hFF});
        op(8'h3C, 8'h5A, {1'b1, 8'hE2});
        op(8'hA5, 8'hA5, {1'b0, 8'h00});

        // start while busy ignored, operand changes mid-run ignored
        @(negedge clk);
        a = 8'hC3;
        b = 8'h21;
        start = 1'b1;
        sb.push_back({1'b0, 8'hA2});
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h0F;
        b = 8'hF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'h77;
        b = 8'h99;
        wait_done();
        repeat (12) @(negedge clk);

        // reset mid-run aborts with no done
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out", 32'({borrow_out, diff}), 32'd0);
        chk("abort_ctl", 32'({busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        sb.push_back({1'b0, 8'h0F});
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // back-to-back with start in the done cycle
        op(8'hFF, 8'h01, {1'b0, 8'hFE});
        a = 8'h01;
        b = 8'hFF;
        start = 1'b1;
        sb.push_back({1'b1, 8'h02});
        @(negedge clk);
        start = 1'b0;
        wait_done();
        #1;
        chk("done_spacing", 32'(last_done - prev_done), 32'd9);

        // random operands against a-b reference
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            op(ra, rb, {1'b0, ra} - {1'b0, rb});
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  single-cycle pulse when diff and borrow_out are updated.
REQ-009 diff  output  WIDTH  result a-b modulo 2^WIDTH; holds its value until the next completion.
REQ-010 borrow_out  output  1  final borrow, equal to 1 iff a < b unsigned; holds until the next completion.

Function
REQ-011 The design SHALL be a bit-serial subtractor processing one bit per clock, LSB first, with a registered borrow chain.
REQ-012 Per-bit cell: d = ai ^ bi ^ bin; bout = (~ai & bi) | (~(ai ^ bi) & bin). This is the half-subtractor pair cascaded with the borrow-in.
REQ-013 There SHALL be two FSM states, IDLE and RUN; the reset state SHALL be IDLE.
REQ-014 IDLE -> RUN on an edge with start=1. On that edge:
- load a and b into shift registers;
- clear the borrow register to 0;
- clear the bit counter to 0.
REQ-015 In RUN, each edge SHALL compute one result bit from the shift-register LSBs and the borrow register, then shift the operand registers right by one.
- The result bit SHALL be shifted into the MSB of a result shift register.
- The borrow register SHALL update to bout.
- The counter SHALL increment.
REQ-016 On the edge processing bit WIDTH-1, the block SHALL:
- transition RUN -> IDLE;
- load diff from the completed result register;
- load borrow_out from the final bout;
- set done=1.
REQ-017 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge E(WIDTH) and low after E(WIDTH+1) unless another completion occurs.
REQ-018 busy SHALL be registered. It SHALL be high from after E0 through edge E(WIDTH), and low in the cycle in which done is high.
REQ-019 start while busy=1 SHALL be ignored; operands, counter and outputs are unaffected.
REQ-020 start in the cycle where done=1 SHALL be accepted (back-to-back). diff and borrow_out keep the just-completed values until the next completion.
REQ-021 Changes to a and b after acceptance SHALL NOT affect the result.
REQ-022 diff and borrow_out SHALL change only on a completion edge or on reset; they SHALL never expose partial results.
REQ-023 The counter SHALL be sized ceil(log2(WIDTH))+1 bits; wrap-around is not permitted.

Reset
REQ-024 When rst_n=0, the block SHALL immediately, independent of clk, force:
- state IDLE, busy=0, done=0;
- diff all-zeros, borrow_out=0;
- shift registers, borrow register and counter to 0.
REQ-025 Reset asserted mid-operation SHALL abort that operation with no done pulse. After release, the first start SHALL behave as from power-up.
REQ-026 start sampled on the first edge after rst_n deasserts SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, a=8'h5A, b=8'h3C, start pulse -> busy high 8 cycles, then done pulse with diff=8'h1E, borrow_out=0.
REQ-028 a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1; also a=8'h3C, b=8'h5A -> diff=8'hE2, borrow_out=1.
REQ-029 a=b=8'hA5 -> diff=8'h00, borrow_out=0.
REQ-030 Apply start again at cycle 3 of a run with different operands; also change a and b mid-run -> first result unchanged, exactly one done pulse.
REQ-031 Assert rst_n=0 at cycle 4 of a run -> outputs zero immediately, no done pulse. A following 8'h10-8'h01 run -> diff=8'h0F, borrow_out=0.
REQ-032 Back-to-back runs with start high in the done cycle: 8'hFF-8'h01 then 8'h01-8'hFF.
- Expected diffs 8'hFE then 8'h02; borrows 0 then 1.
- done pulses exactly 9 cycles apart.
- Random operands across the test SHALL be checked against a reference model of a-b.
